p405s_icu_vb_reader: RTL and testbench

- Read-side companion to the ICU valid-bit write path.
- Holds the per-way valid-bit arrays, 32 congruence classes per way. Applies single-bit writes and flash clears from the fill/invalidate logic.
- Services registered tag-lookup reads with write-first bypass.
- Contains a sequential search engine that locates the next invalid entry in a way for fill allocation.
- Sits between the ICU fill sequencer and the IFetch lookup stage.

---
 rtl/p405s_icu_vb_reader.sv | 148 ++++++++++++++
 tb/tb_p405s_icu_vb_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_icu_vb_reader.sv
// ICU valid-bit array with registered lookup reads (write-first bypass) and a
// sequential search engine that finds the next invalid entry for fill allocation.
module p405s_icu_vb_reader #(
  parameter int NWAYS = 2,
  parameter int NENT  = 32
) (
  input  logic             CB,
  input  logic             resetL,
  input  logic             wrEn,
  input  logic             wrWay,
  input  logic [4:8]       wrIndex,
  input  logic             wrBit,
  input  logic             wrFlash,
  input  logic             rdReq,
  input  logic [4:8]       rdIndex,
  output logic             rdVld,
  output logic [0:NWAYS-1] rdVb,
  input  logic             srchReq,
  input  logic             srchWay,
  output logic             srchBusy,
  output logic             srchDone,
  output logic             srchHit,
  output logic [4:8]       srchIndex,
  output logic [0:31]      vbW0,
  output logic [0:31]      vbW1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [0:NENT-1]  vb_q [NWAYS];
  logic [0:NENT-1]  vb_d [NWAYS];
  logic             rd_vld_q, rd_vld_d;
  logic [0:NWAYS-1] rd_vb_q, rd_vb_d;
  state_t           state_q, state_d;
  logic             way_q, way_d;
  logic [4:0]       cur_q, cur_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [4:0]       ptr_q, ptr_d;
  logic             hit_q, hit_d;
  logic [4:0]       idx_q, idx_d;

  // Post-write array view; it feeds the registers, the read bypass and the scan.
  always_comb begin
    vb_d = vb_q;
    if (wrFlash) begin
      for (int w = 0; w < NWAYS; w++) begin
        vb_d[w] = '0;
      end
    end else if (wrEn) begin
      vb_d[wrWay][wrIndex] = wrBit;
    end
  end

  always_comb begin
    rd_vld_d = rdReq;
    rd_vb_d  = rd_vb_q;
    if (rdReq) begin
      for (int w = 0; w < NWAYS; w++) begin
        rd_vb_d[w] = vb_d[w][rdIndex];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (srchReq) begin
          way_d   = srchWay;
          cur_d   = ptr_q;
          cnt_d   = 6'd0;
          hit_d   = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!vb_d[way_q][cur_q]) begin
          hit_d   = 1'b1;
          idx_d   = cur_q;
          state_d = S_DONE;
        end else begin
          cur_d = cur_q + 5'd1;
          cnt_d = cnt_q + 6'd1;
          // Last of the 32 entries was valid: the way is full.
          if (cnt_q == 6'd31) begin
            hit_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (hit_q) begin
          ptr_d = idx_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CB or negedge resetL) begin
    if (!resetL) begin
      for (int w = 0; w < NWAYS; w++) begin
        vb_q[w] <= '0;
      end
      rd_vld_q <= 1'b0;
      rd_vb_q  <= '0;
      state_q  <= S_IDLE;
      way_q    <= 1'b0;
      cur_q    <= 5'd0;
      cnt_q    <= 6'd0;
      ptr_q    <= 5'd0;
      hit_q    <= 1'b0;
      idx_q    <= 5'd0;
    end else begin
      vb_q     <= vb_d;
      rd_vld_q <= rd_vld_d;
      rd_vb_q  <= rd_vb_d;
      state_q  <= state_d;
      way_q    <= way_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
    end
  end

  assign rdVld     = rd_vld_q;
  assign rdVb      = rd_vb_q;
  assign srchBusy  = (state_q == S_SCAN);
  assign srchDone  = (state_q == S_DONE);
  assign srchHit   = hit_q;
  assign srchIndex = idx_q;
  assign vbW0      = vb_q[0];
  assign vbW1      = vb_q[1];

endmodule

// File: tb/tb_p405s_icu_vb_reader.sv
// Bench for p405s_icu_vb_reader: directed scenarios plus random traffic against
// a cycle-level behavioural model of the valid arrays, reads and search.
module tb_p405s_icu_vb_reader;

  logic        CB = 1'b0;
  logic        resetL;
  logic        wrEn, wrWay, wrBit, wrFlash;
  logic [4:8]  wrIndex;
  logic        rdReq;
  logic [4:8]  rdIndex;
  logic        rdVld;
  logic [0:1]  rdVb;
  logic        srchReq, srchWay;
  logic        srchBusy, srchDone, srchHit;
  logic [4:8]  srchIndex;
  logic [0:31] vbW0, vbW1;

  int tests = 0;
  int fails = 0;

  always #5 CB = ~CB;

  p405s_icu_vb_reader #(.NWAYS(2), .NENT(32)) dut (
    .CB(CB), .resetL(resetL),
    .wrEn(wrEn), .wrWay(wrWay), .wrIndex(wrIndex), .wrBit(wrBit), .wrFlash(wrFlash),
    .rdReq(rdReq), .rdIndex(rdIndex), .rdVld(rdVld), .rdVb(rdVb),
    .srchReq(srchReq), .srchWay(srchWay), .srchBusy(srchBusy), .srchDone(srchDone),
    .srchHit(srchHit), .srchIndex(srchIndex), .vbW0(vbW0), .vbW1(vbW1)
  );

  // Reference model state
  bit m_vb [2][32];
  bit e_rdvld, e_rv0, e_rv1;
  bit m_scan, m_done, m_hit, m_way;
  int m_idx, m_ptr, m_start, m_k;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] packw(input int w);
    logic [31:0] v;
    for (int n = 0; n < 32; n++) v[31-n] = m_vb[w][n];
    return v;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int n = 0; n < 32; n++) m_vb[w][n] = 1'b0;
    e_rdvld = 0; e_rv0 = 0; e_rv1 = 0;
    m_scan = 0; m_done = 0; m_hit = 0; m_way = 0;
    m_idx = 0; m_ptr = 0; m_start = 0; m_k = 0;
  endtask

  task automatic model_step();
    bit p [2][32];
    int e;
    p = m_vb;
    if (wrFlash) begin
      for (int w = 0; w < 2; w++)
        for (int n = 0; n < 32; n++) p[w][n] = 1'b0;
    end else if (wrEn) begin
      p[int'(wrWay)][int'(wrIndex)] = wrBit;
    end
    if (rdReq) begin
      e_rdvld = 1;
      e_rv0 = p[0][int'(rdIndex)];
      e_rv1 = p[1][int'(rdIndex)];
    end else begin
      e_rdvld = 0;
    end
    if (m_done) begin
      m_done = 0;
      if (m_hit) m_ptr = (m_idx + 1) % 32;
    end else if (m_scan) begin
      e = (m_start + m_k) % 32;
      if (p[int'(m_way)][e] == 1'b0) begin
        m_hit = 1; m_idx = e; m_scan = 0; m_done = 1;
      end else begin
        m_k++;
        if (m_k == 32) begin
          m_hit = 0; m_scan = 0; m_done = 1;
        end
      end
    end else if (srchReq) begin
      m_scan = 1; m_way = srchWay; m_start = m_ptr; m_k = 0; m_hit = 0;
    end
    m_vb = p;
  endtask

  task automatic check_outputs();
    chk("rdVld", rdVld, e_rdvld);
    chk("rdVb", rdVb, {e_rv0, e_rv1});
    chk("srchBusy", srchBusy, m_scan);
    chk("srchDone", srchDone, m_done);
    if (m_done) begin
      chk("srchHit", srchHit, m_hit);
      if (m_hit) chk("srchIndex", srchIndex, m_idx[4:0]);
    end
    chk("vbW0", vbW0, packw(0));
    chk("vbW1", vbW1, packw(1));
  endtask

  task automatic cycle();
    model_step();
    @(posedge CB); #1;
    check_outputs();
  endtask

  task automatic idle_in();
    wrEn = 0; wrWay = 0; wrIndex = '0; wrBit = 0; wrFlash = 0;
    rdReq = 0; rdIndex = '0; srchReq = 0; srchWay = 0;
  endtask

  task automatic wr(input logic way, input int idx, input logic b);
    wrEn = 1; wrWay = way; wrIndex = 5'(idx); wrBit = b;
    cycle();
    idle_in();
  endtask

  task automatic run_search(input logic way, output int scans);
    int guard;
    srchReq = 1; srchWay = way;
    cycle();
    idle_in();
    scans = 0; guard = 0;
    while (!srchDone && guard < 40) begin
      if (srchBusy) scans++;
      cycle();
      guard++;
    end
    if (guard >= 40) chk("srch_timeout", 1'b0, 1'b1);
  endtask

  task automatic async_reset();
    resetL = 0;
    #1;
    model_reset();
    chk("rst_busy", srchBusy, 1'b0);
    chk("rst_done", srchDone, 1'b0);
    chk("rst_vbW0", vbW0, 32'h0);
    chk("rst_vbW1", vbW1, 32'h0);
    @(negedge CB);
    resetL = 1;
  endtask

  initial begin
    int sc;
    idle_in();
    resetL = 0;
    model_reset();
    #2;
    chk("init_rdVld", rdVld, 1'b0);
    chk("init_rdVb", rdVb, 2'b00);
    chk("init_busy", srchBusy, 1'b0);
    chk("init_done", srchDone, 1'b0);
    chk("init_hit", srchHit, 1'b0);
    chk("init_idx", srchIndex, 5'd0);
    chk("init_vbW0", vbW0, 32'h0);
    chk("init_vbW1", vbW1, 32'h0);
    @(negedge CB);
    resetL = 1;

    rdReq = 1; rdIndex = 5'd5;
    cycle(); idle_in();
    chk("t1_rdVld", rdVld, 1'b1);
    chk("t1_rdVb", rdVb, 2'b00);
    cycle();
    chk("t1_rdVld_off", rdVld, 1'b0);

    wr(1'b1, 31, 1'b1);
    rdReq = 1; rdIndex = 5'd31;
    cycle(); idle_in();
    chk("t2_rdVb", rdVb, 2'b01);
    chk("t2_vbW1", vbW1, 32'h00000001);
    wr(1'b1, 31, 1'b0);
    wrEn = 1; wrWay = 1; wrIndex = 5'd31; wrBit = 1; rdReq = 1; rdIndex = 5'd31;
    cycle(); idle_in();
    chk("t2_bypass_rdVb", rdVb, 2'b01);

    for (int i = 0; i < 10; i++) wr(1'b0, i, 1'b1);
    run_search(1'b0, sc);
    chk("t3_scans", sc, 11);
    chk("t3_hit", srchHit, 1'b1);
    chk("t3_idx", srchIndex, 5'd10);
    cycle();
    run_search(1'b0, sc);
    chk("t3b_scans", sc, 1);
    chk("t3b_idx", srchIndex, 5'd11);
    cycle();

    for (int i = 0; i < 32; i++) wr(1'b0, i, 1'b1);
    run_search(1'b0, sc);
    chk("t4_scans", sc, 32);
    chk("t4_hit", srchHit, 1'b0);
    cycle();
    run_search(1'b0, sc);
    chk("t4_ptr_kept", sc, 32);
    cycle();

    wr(1'b0, 29, 1'b0);
    run_search(1'b0, sc);
    chk("t5a_idx", srchIndex, 5'd29);
    cycle();
    wr(1'b0, 29, 1'b1);
    wr(1'b0, 0, 1'b0);
    run_search(1'b0, sc);
    chk("t5_scans", sc, 3);
    chk("t5_hit", srchHit, 1'b1);
    chk("t5_idx", srchIndex, 5'd0);
    cycle();

    for (int i = 0; i < 32; i++) wr(1'b0, i, 1'b1);
    srchReq = 1; srchWay = 0;
    cycle(); idle_in();
    for (int i = 0; i < 5; i++) cycle();
    wrFlash = 1; rdReq = 1; rdIndex = 5'd3;
    cycle(); idle_in();
    chk("t6_rdVb", rdVb, 2'b00);
    chk("t6_done", srchDone, 1'b1);
    chk("t6_hit", srchHit, 1'b1);
    chk("t6_idx", srchIndex, 5'd6);
    chk("t6_vbW0", vbW0, 32'h0);
    chk("t6_vbW1", vbW1, 32'h0);
    cycle();

    for (int i = 7; i < 10; i++) wr(1'b1, i, 1'b1);
    srchReq = 1; srchWay = 1;
    cycle(); idle_in();
    cycle(); cycle();
    async_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t7_no_done", srchDone, 1'b0);
    end

    for (int c = 0; c < 3000; c++) begin
      wrEn    = ($urandom_range(0, 99) < 60);
      wrWay   = 1'($urandom_range(0, 1));
      wrIndex = 5'($urandom_range(0, 31));
      wrBit   = ($urandom_range(0, 99) < 85);
      wrFlash = ($urandom_range(0, 99) < 2);
      rdReq   = ($urandom_range(0, 99) < 50);
      rdIndex = 5'($urandom_range(0, 31));
      srchReq = ($urandom_range(0, 99) < 30);
      srchWay = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) < 2) begin
        idle_in();
        async_reset();
      end
      cycle();
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
